shm_shift_pipe: RTL

- Parametrised, pipelined successor to the EBOX shift matrix.
- Produces one W-bit result per accepted operation from a double-word operand pair (hi = AR-side, lo = ARX-side) and a shift count.
- Adds rotate and arithmetic-right modes, a saturating count rule, result parity, and a valid/ready pipeline with backpressure.
- Sits between the EDP AR/ARX sources and the SH consumers (AD/BR muxes, EBUS).

---
 rtl/shm_pkg.sv | 23 ++
 rtl/shm_shift_core.sv | 59 +++++
 rtl/shm_shift_pipe.sv | 77 +++++++
 3 files changed

// File: rtl/shm_pkg.sv
// Shared types and elaboration checks for the pipelined shift matrix.
// The mode encoding is shared by the core and the testbench.
package shm_pkg;

  typedef enum logic [2:0] {
    FUNNEL  = 3'd0,
    PASS_HI = 3'd1,
    PASS_LO = 3'd2,
    SWAP    = 3'd3,
    ROTL    = 3'd4,
    ASHR    = 3'd5,
    RSV6    = 3'd6,
    RSV7    = 3'd7
  } shm_mode_t;

  localparam int PIPE_MIN = 1;
  localparam int PIPE_MAX = 3;

  function automatic bit pipe_ok(input int pipe);
    return (pipe >= PIPE_MIN) && (pipe <= PIPE_MAX);
  endfunction

endpackage

// File: rtl/shm_shift_core.sv
// Combinational shift matrix: mode decode, saturation, mod-W rotate and
// arithmetic-right fill. Everything is resolved here so later stages only register.
module shm_shift_core
  import shm_pkg::*;
#(
  parameter int W   = 36,
  parameter int SCW = 8
) (
  input  logic [2:0]     mode,
  input  logic [W-1:0]   hi,
  input  logic [W-1:0]   lo,
  input  logic [SCW-1:0] sc,
  output logic [W-1:0]   sh,
  output logic           bad_mode
);

  if (W % 2 != 0) begin : g_w_check
    $error("shm_shift_core: W must be even");
  end

  // The count is widened past both SCW and 32 bits so no upper bits of sc
  // are lost before the saturation compare.
  localparam int XW = ((SCW > 32) ? SCW : 32) + 1;
  localparam int RW = $clog2(W);
  localparam logic [XW-1:0] W_X = XW'(W);

  shm_mode_t     op;
  logic [XW-1:0] sc_x;
  logic          sat;
  logic [RW-1:0] rot_amt;
  logic [W-1:0]  funnel;
  logic [W-1:0]  rotl;
  logic [W-1:0]  ashr;

  assign op      = shm_mode_t'(mode);
  assign sc_x    = XW'(sc);
  assign sat     = (sc_x >= W_X);
  assign rot_amt = RW'(sc_x % W_X);

  assign funnel = sat ? lo : W'(({hi, lo} << sc) >> W);
  assign rotl   = W'(({hi, hi} << rot_amt) >> W);
  assign ashr   = sat ? {W{hi[W-1]}} : $unsigned($signed(hi) >>> sc);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs (no latches).
    sh       = '0;
    bad_mode = 1'b0;
    case (op)
      FUNNEL:  sh = funnel;
      PASS_HI: sh = hi;
      PASS_LO: sh = lo;
      SWAP:    sh = {hi[W/2-1:0], hi[W-1:W/2]};
      ROTL:    sh = rotl;
      ASHR:    sh = ashr;
      default: bad_mode = 1'b1;
    endcase
  end

endmodule

// File: rtl/shm_shift_pipe.sv
// Pipelined shift matrix: a PIPE-deep valid/payload chain behind shm_shift_core,
// advanced by a single global enable so a stall freezes every stage together.
module shm_shift_pipe
  import shm_pkg::*;
#(
  parameter int W    = 36,
  parameter int SCW  = 8,
  parameter int PIPE = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     mode,
  input  logic [W-1:0]   hi,
  input  logic [W-1:0]   lo,
  input  logic [SCW-1:0] sc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   sh,
  output logic           sh_par_odd,
  output logic           bad_mode
);

  if (!pipe_ok(PIPE)) begin : g_pipe_check
    $error("shm_shift_pipe: PIPE must be in 1..3");
  end

  typedef struct packed {
    logic [W-1:0] sh;
    logic         bad_mode;
  } stage_t;

  logic            adv;
  logic [PIPE-1:0] vld;
  stage_t          pay [PIPE];
  logic [W-1:0]    core_sh;
  logic            core_bad;

  shm_shift_core #(
    .W   (W),
    .SCW (SCW)
  ) u_core (
    .mode     (mode),
    .hi       (hi),
    .lo       (lo),
    .sc       (sc),
    .sh       (core_sh),
    .bad_mode (core_bad)
  );

  // The whole pipe moves whenever the output slot is empty or being drained.
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[PIPE-1];

  // NOTE: non-blocking assignments so every stage samples its predecessor's
  // pre-edge value. Payload is reset too, because sh must read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < PIPE; i++) pay[i] <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      pay[0] <= '{sh: core_sh, bad_mode: core_bad};
      for (int i = 1; i < PIPE; i++) begin
        vld[i] <= vld[i-1];
        pay[i] <= pay[i-1];
      end
    end
  end

  assign sh         = pay[PIPE-1].sh;
  assign bad_mode   = pay[PIPE-1].bad_mode;
  assign sh_par_odd = ^pay[PIPE-1].sh;

endmodule
